// File: rtl/d_reg_scoreboard_if.sv
// Bundle of the D-stage scoreboard signals: source reads, issue, W-stage
// commit, cancel, and the hazard/occupancy outputs.
interface d_reg_scoreboard_if #(
  parameter int TOT_W = 4
);
  logic [4:0]       rd_a1;
  logic [4:0]       rd_a2;
  logic             rd_use1;
  logic             rd_use2;
  logic             issue_en;
  logic [4:0]       issue_a3;
  logic             wb_en;
  logic [4:0]       wb_a3;
  logic             kill_en;
  logic [4:0]       kill_a3;
  logic             stall1;
  logic             stall2;
  logic             stall;
  logic [31:0]      pending_mask;
  logic [TOT_W-1:0] inflight;
  logic             err;

  // Pipeline / hazard controller side.
  modport master (
    output rd_a1, rd_a2, rd_use1, rd_use2, issue_en, issue_a3,
           wb_en, wb_a3, kill_en, kill_a3,
    input  stall1, stall2, stall, pending_mask, inflight, err
  );

  // Scoreboard side.
  modport slave (
    input  rd_a1, rd_a2, rd_use1, rd_use2, issue_en, issue_a3,
           wb_en, wb_a3, kill_en, kill_a3,
    output stall1, stall2, stall, pending_mask, inflight, err
  );
endinterface

// File: rtl/d_reg_scoreboard.sv
// D-stage register scoreboard: counts in-flight GRF writes per destination
// register from issue until W-stage commit (or cancel) and flags read-after-write
// hazards for the instruction sitting in D, honouring the GRF's same-cycle
// W-to-D bypass. Counters saturate and raise a sticky err on over/underflow.
// Optional macro SB_TRACE_EN: prints one line per event at each clock edge.
module d_reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int TOT_W = 4
) (
  input  logic clk,
  input  logic reset,
  d_reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W+1:0] CMAX_W = {2'b00, {CNT_W{1'b1}}};
  localparam logic [TOT_W+1:0] TMAX_W = {2'b00, {TOT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      ovf_v;
  logic [31:0]      unf_v;
  logic [31:0]      pend_q;
  logic [31:0]      pend_d;
  logic [TOT_W-1:0] tot_q;
  logic [TOT_W-1:0] tot_d;
  logic             tot_err;
  logic             err_q;
  logic             err_d;
  logic             inc_any;
  logic [1:0]       dec_any;
  logic             hit1;
  logic             hit2;
  logic             stall1;
  logic             stall2;

  // Per-register and total counter next state with saturate-and-flag arithmetic.
  always_comb begin
    ovf_v  = '0;
    unf_v  = '0;
    pend_d = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < 32; r++) begin
      logic [1:0]       dec_n;
      logic [CNT_W+1:0] up_c;
      logic [CNT_W+1:0] dec_c;
      logic [CNT_W+1:0] res_c;
      dec_n = {1'b0, sb.wb_en && sb.wb_a3 == 5'(r)}
            + {1'b0, sb.kill_en && sb.kill_a3 == 5'(r)};
      up_c  = {2'b00, cnt_q[r]}
            + {{(CNT_W+1){1'b0}}, sb.issue_en && sb.issue_a3 == 5'(r)};
      dec_c = {{CNT_W{1'b0}}, dec_n};
      res_c = up_c - dec_c;
      if (up_c < dec_c) begin
        cnt_d[r] = '0;
        unf_v[r] = 1'b1;
      end else if (res_c > CMAX_W) begin
        cnt_d[r] = {CNT_W{1'b1}};
        ovf_v[r] = 1'b1;
      end else begin
        cnt_d[r] = res_c[CNT_W-1:0];
      end
      pend_d[r] = cnt_d[r] != '0;
    end
  end

  // Aggregate in-flight count follows the same net arithmetic as the per-register counters.
  always_comb begin
    logic [TOT_W+1:0] t_up;
    logic [TOT_W+1:0] t_dec;
    logic [TOT_W+1:0] t_res;
    inc_any = sb.issue_en && sb.issue_a3 != 5'd0;
    dec_any = {1'b0, sb.wb_en && sb.wb_a3 != 5'd0}
            + {1'b0, sb.kill_en && sb.kill_a3 != 5'd0};
    t_up    = {2'b00, tot_q} + {{(TOT_W+1){1'b0}}, inc_any};
    t_dec   = {{TOT_W{1'b0}}, dec_any};
    t_res   = t_up - t_dec;
    tot_err = 1'b0;
    if (t_up < t_dec) begin
      tot_d   = '0;
      tot_err = 1'b1;
    end else if (t_res > TMAX_W) begin
      tot_d   = {TOT_W{1'b1}};
      tot_err = 1'b1;
    end else begin
      tot_d = t_res[TOT_W-1:0];
    end
  end

  // Hazard detect: a register committing this cycle counts one less, matching
  // the GRF bypass. A write to an idle register is not treated as a hazard.
  always_comb begin
    hit1   = sb.wb_en && sb.wb_a3 == sb.rd_a1;
    hit2   = sb.wb_en && sb.wb_a3 == sb.rd_a2;
    stall1 = sb.rd_use1 && sb.rd_a1 != 5'd0
          && ({1'b0, cnt_q[sb.rd_a1]} > {{CNT_W{1'b0}}, hit1});
    stall2 = sb.rd_use2 && sb.rd_a2 != 5'd0
          && ({1'b0, cnt_q[sb.rd_a2]} > {{CNT_W{1'b0}}, hit2});
    err_d  = err_q || (|ovf_v) || (|unf_v) || tot_err
          || (sb.issue_en && (stall1 || stall2));
  end

  // State registers; reset throws away every pending write at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      pend_q <= '0;
      tot_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pend_q <= pend_d;
      tot_q  <= tot_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall1       = stall1;
  assign sb.stall2       = stall2;
  assign sb.stall        = stall1 | stall2;
  assign sb.pending_mask = pend_q;
  assign sb.inflight     = tot_q;
  assign sb.err          = err_q;

`ifdef SB_TRACE_EN
  // Event log printed at the edge that applies the event, with post-update counts.
  always @(posedge clk) begin
    if (reset) begin
      if (sb.issue_en && sb.issue_a3 != 5'd0)
        $display("SB issue $%d cnt=%d", sb.issue_a3, cnt_d[sb.issue_a3]);
      if (sb.wb_en && sb.wb_a3 != 5'd0)
        $display("SB retire $%d cnt=%d", sb.wb_a3, cnt_d[sb.wb_a3]);
      if (sb.kill_en && sb.kill_a3 != 5'd0)
        $display("SB kill $%d cnt=%d", sb.kill_a3, cnt_d[sb.kill_a3]);
      for (int r = 1; r < 32; r++) begin
        if (ovf_v[r] || unf_v[r])
          $display("SB ERR $%d", 5'(r));
      end
    end
  end
`endif

endmodule

// File: tb/tb_d_reg_scoreboard.sv
module tb_d_reg_scoreboard;
  localparam int CNT_W = 2;
  localparam int TOT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int TMAX  = (1 << TOT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_reg_scoreboard_if #(.TOT_W(TOT_W)) sb ();

  d_reg_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: plain integer counts of outstanding writes.
  int m_cnt [32];
  int m_tot;
  bit m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit m_haz(input logic [4:0] a, input logic u,
                               input logic we, input logic [4:0] wa);
    int eff;
    if (!u || a == 5'd0) return 1'b0;
    eff = m_cnt[a] - ((we && wa == a) ? 1 : 0);
    return eff > 0;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) m[r] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_tot = 0;
    m_err = 1'b0;
  endtask

  // Apply the current inputs to the model as the coming clock edge would.
  task automatic m_update();
    int d [32];
    int n;
    int dt;
    bit st;
    st = m_haz(sb.rd_a1, sb.rd_use1, sb.wb_en, sb.wb_a3)
      || m_haz(sb.rd_a2, sb.rd_use2, sb.wb_en, sb.wb_a3);
    if (sb.issue_en && st) m_err = 1'b1;
    for (int r = 0; r < 32; r++) d[r] = 0;
    dt = 0;
    if (sb.issue_en && sb.issue_a3 != 0) begin d[sb.issue_a3]++; dt++; end
    if (sb.wb_en && sb.wb_a3 != 0)       begin d[sb.wb_a3]--;    dt--; end
    if (sb.kill_en && sb.kill_a3 != 0)   begin d[sb.kill_a3]--;  dt--; end
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r] + d[r];
      if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
      if (n < 0)    begin n = 0;    m_err = 1'b1; end
      m_cnt[r] = n;
    end
    n = m_tot + dt;
    if (n > TMAX) begin n = TMAX; m_err = 1'b1; end
    if (n < 0)    begin n = 0;    m_err = 1'b1; end
    m_tot = n;
  endtask

  task automatic drive(input logic ie, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                       input logic ke, input logic [4:0] ka,
                       input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    sb.issue_en = ie; sb.issue_a3 = ia;
    sb.wb_en    = we; sb.wb_a3    = wa;
    sb.kill_en  = ke; sb.kill_a3  = ka;
    sb.rd_a1    = a1; sb.rd_use1  = u1;
    sb.rd_a2    = a2; sb.rd_use2  = u2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic verify(input string tag);
    bit s1, s2;
    s1 = m_haz(sb.rd_a1, sb.rd_use1, sb.wb_en, sb.wb_a3);
    s2 = m_haz(sb.rd_a2, sb.rd_use2, sb.wb_en, sb.wb_a3);
    check({tag, ".stall1"},   64'(sb.stall1), 64'(s1));
    check({tag, ".stall2"},   64'(sb.stall2), 64'(s2));
    check({tag, ".stall"},    64'(sb.stall), 64'(s1 | s2));
    check({tag, ".pending"},  64'(sb.pending_mask), 64'(m_mask()));
    check({tag, ".inflight"}, 64'(sb.inflight), 64'(m_tot));
    check({tag, ".err"},      64'(sb.err), 64'(m_err));
  endtask

  // Model and DUT advance across one rising edge; inputs change 1 time unit later.
  task automatic tick();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    #1;
    verify(tag);
    tick();
  endtask

  initial begin
    logic [4:0] a;
    m_reset();
    reset = 1'b0;
    idle();
    #12;
    verify("rst");
    check("rst.pending_const", 64'(sb.pending_mask), 64'h0);
    check("rst.inflight_const", 64'(sb.inflight), 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Issue $5, then look for the hazard
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0); step("iss5");
    drive(0, 0, 0, 0, 0, 0, 5, 1, 0, 0); #1; verify("haz5");
    check("haz5.pending_const", 64'(sb.pending_mask), 64'h20);
    check("haz5.inflight_const", 64'(sb.inflight), 64'd1);
    check("haz5.stall1_const", 64'(sb.stall1), 64'd1);
    check("haz5.stall_const", 64'(sb.stall), 64'd1);
    sb.rd_use1 = 1'b0; #1;
    check("haz5.nouse_const", 64'(sb.stall1), 64'd0);

    // Same-cycle bypass
    drive(0, 0, 1, 5, 0, 0, 0, 0, 5, 1); #1; verify("byp");
    check("byp.stall2_const", 64'(sb.stall2), 64'd0);
    tick();
    idle(); #1; verify("byp_after");
    check("byp_after.pending_const", 64'(sb.pending_mask), 64'h0);

    // Double writer to $8
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0); step("dbl_i1");
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0); step("dbl_i2");
    drive(0, 0, 1, 8, 0, 0, 8, 1, 0, 0); #1; verify("dbl_w1");
    check("dbl_w1.stall1_const", 64'(sb.stall1), 64'd1);
    tick();
    drive(0, 0, 1, 8, 0, 0, 8, 1, 0, 0); #1; verify("dbl_w2");
    check("dbl_w2.stall1_const", 64'(sb.stall1), 64'd0);
    tick();
    idle(); #1; verify("dbl_end");
    check("dbl_end.inflight_const", 64'(sb.inflight), 64'd0);

    // Register 0 is never tracked
    drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0); #1; verify("r0");
    check("r0.stall1_const", 64'(sb.stall1), 64'd0);
    tick();
    idle(); #1; verify("r0_after");
    check("r0_after.err_const", 64'(sb.err), 64'd0);

    // Overflow on $3, then underflow on $9
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step("sat_iss");
    end
    idle(); #1; verify("sat_ovf");
    check("sat_ovf.err_const", 64'(sb.err), 64'd1);
    check("sat_ovf.inflight_const", 64'(sb.inflight), 64'd4);
    drive(0, 0, 1, 9, 0, 0, 0, 0, 0, 0); step("sat_unf");
    idle(); #1; verify("sat_unf_after");
    check("sat_unf.pending_const", 64'(sb.pending_mask), 64'h8);

    // Clear, then async reset mid-flight
    reset = 1'b0; m_reset(); #1; reset = 1'b1; #1;
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0); step("ar_i4");
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0); step("ar_i7");
    drive(0, 0, 0, 0, 0, 0, 4, 1, 7, 1); #1; verify("ar_pre");
    #1; reset = 1'b0; m_reset(); #1;
    verify("ar_async");
    check("ar_async.stall_const", 64'(sb.stall), 64'd0);
    reset = 1'b1;
    tick();
    drive(0, 0, 1, 4, 0, 0, 0, 0, 0, 0); step("ar_wb4");
    idle(); #1; verify("ar_err");
    check("ar_err.err_const", 64'(sb.err), 64'd1);

    // Randomized traffic against the model
    reset = 1'b0; m_reset(); #1; reset = 1'b1; #1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 150 == 149) begin
        #2; reset = 1'b0; m_reset(); #1; verify("rnd_rst"); reset = 1'b1;
        tick();
      end
      sb.rd_a1 = 5'($urandom_range(0, 7)); sb.rd_use1 = 1'($urandom);
      sb.rd_a2 = 5'($urandom_range(0, 7)); sb.rd_use2 = 1'($urandom);
      sb.wb_en = ($urandom_range(0, 9) < 4);
      a = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_cnt[5'((int'(a) + k) % 8)] != 0) begin
            a = 5'((int'(a) + k) % 8);
            break;
          end
        end
      end
      sb.wb_a3    = a;
      sb.kill_en  = ($urandom_range(0, 9) == 0);
      sb.kill_a3  = 5'($urandom_range(0, 7));
      sb.issue_a3 = 5'($urandom_range(0, 7));
      sb.issue_en = ($urandom_range(0, 2) == 0);
      if ((m_haz(sb.rd_a1, sb.rd_use1, sb.wb_en, sb.wb_a3)
           || m_haz(sb.rd_a2, sb.rd_use2, sb.wb_en, sb.wb_a3))
          && $urandom_range(0, 9) != 0)
        sb.issue_en = 1'b0;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
